// File: rtl/axi4_burst_master.sv
// AXI4 burst self-test master: writes an incrementing burst, reads it back,
// and reports any data, last-beat or response mismatch on a sticky error flag.
module axi4_burst_master #(
    parameter int                      C_ADDR_WIDTH = 32,
    parameter int                      C_BURST_LEN  = 8,
    parameter logic [C_ADDR_WIDTH-1:0] C_BASE_ADDR  = {C_ADDR_WIDTH{1'b0}}
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    start,
    output logic                    done,
    output logic                    error,
    output logic [3:0]              AWID,
    output logic [C_ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]              AWLEN,
    output logic [2:0]              AWSIZE,
    output logic [1:0]              AWBURST,
    output logic                    AWLOCK,
    output logic [3:0]              AWCACHE,
    output logic [2:0]              AWPROT,
    output logic [3:0]              AWQOS,
    output logic [3:0]              AWREGION,
    output logic                    AWUSER,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [31:0]             WDATA,
    output logic [3:0]              WSTRB,
    output logic                    WLAST,
    output logic                    WUSER,
    output logic                    WVALID,
    input  logic                    WREADY,
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY,
    output logic [3:0]              ARID,
    output logic [C_ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]              ARLEN,
    output logic [2:0]              ARSIZE,
    output logic [1:0]              ARBURST,
    output logic                    ARLOCK,
    output logic [3:0]              ARCACHE,
    output logic [2:0]              ARPROT,
    output logic [3:0]              ARQOS,
    output logic [3:0]              ARREGION,
    output logic                    ARUSER,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    input  logic [31:0]             RDATA,
    input  logic [1:0]              RRESP,
    input  logic                    RLAST,
    input  logic                    RVALID,
    output logic                    RREADY
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_WRESP  = 3'd2,
        S_RADDR  = 3'd3,
        S_RDATA  = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    localparam logic [8:0] LAST_BEAT = 9'(C_BURST_LEN - 1);

    state_t     state_r;
    state_t     state_s;
    logic [8:0] wbeat_r;
    logic [8:0] rbeat_r;
    logic       aw_done_r;
    logic       w_done_r;
    logic       error_r;
    logic       done_r;
    logic       aw_hs_s;
    logic       w_hs_s;
    logic       r_hs_s;
    logic       r_bad_s;

    assign AWID     = 4'd0;
    assign AWADDR   = C_BASE_ADDR;
    assign AWLEN    = 8'(C_BURST_LEN - 1);
    assign AWSIZE   = 3'b010;
    assign AWBURST  = 2'b01;
    assign AWLOCK   = 1'b0;
    assign AWCACHE  = 4'd0;
    assign AWPROT   = 3'd0;
    assign AWQOS    = 4'd0;
    assign AWREGION = 4'd0;
    assign AWUSER   = 1'b0;
    assign WSTRB    = 4'hF;
    assign WUSER    = 1'b0;
    assign ARID     = 4'd0;
    assign ARADDR   = C_BASE_ADDR;
    assign ARLEN    = 8'(C_BURST_LEN - 1);
    assign ARSIZE   = 3'b010;
    assign ARBURST  = 2'b01;
    assign ARLOCK   = 1'b0;
    assign ARCACHE  = 4'd0;
    assign ARPROT   = 3'd0;
    assign ARQOS    = 4'd0;
    assign ARREGION = 4'd0;
    assign ARUSER   = 1'b0;

    // Channel controls decode only from registers, so reset clears them without a clock.
    assign AWVALID = (state_r == S_WRITE) && !aw_done_r;
    assign WVALID  = (state_r == S_WRITE) && !w_done_r;
    assign WLAST   = WVALID && (wbeat_r == LAST_BEAT);
    assign WDATA   = {23'd0, wbeat_r} + 32'd1;
    assign BREADY  = (state_r == S_WRESP);
    assign ARVALID = (state_r == S_RADDR);
    assign RREADY  = (state_r == S_RDATA);
    assign done    = done_r;
    assign error   = error_r;

    assign aw_hs_s = AWVALID && AWREADY;
    assign w_hs_s  = WVALID && WREADY;
    assign r_hs_s  = RVALID && RREADY;
    assign r_bad_s = (RDATA != ({23'd0, rbeat_r} + 32'd1)) || (RRESP != 2'b00) ||
                     (RLAST != (rbeat_r == LAST_BEAT));

    // State register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_s = S_WRITE;
                else       state_s = S_IDLE;
            end
            S_WRITE: begin
                if (aw_done_r && w_done_r) state_s = S_WRESP;
                else                       state_s = S_WRITE;
            end
            S_WRESP: begin
                if (BVALID) state_s = S_RADDR;
                else        state_s = S_WRESP;
            end
            S_RADDR: begin
                if (ARREADY) state_s = S_RDATA;
                else         state_s = S_RADDR;
            end
            S_RDATA: begin
                if (r_hs_s && (rbeat_r == LAST_BEAT)) state_s = S_FINISH;
                else                                  state_s = S_RDATA;
            end
            S_FINISH: state_s = S_IDLE;
            default:  state_s = S_IDLE;
        endcase
    end

    // Beat counters, handshake flags, sticky error and the done pulse.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wbeat_r   <= 9'd0;
            rbeat_r   <= 9'd0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            error_r   <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= (state_r == S_FINISH);
            case (state_r)
                S_IDLE: begin
                    wbeat_r   <= 9'd0;
                    rbeat_r   <= 9'd0;
                    aw_done_r <= 1'b0;
                    w_done_r  <= 1'b0;
                    if (start) error_r <= 1'b0;
                end
                S_WRITE: begin
                    if (aw_hs_s) aw_done_r <= 1'b1;
                    if (w_hs_s) begin
                        wbeat_r <= wbeat_r + 9'd1;
                        if (WLAST) w_done_r <= 1'b1;
                    end
                end
                S_WRESP: begin
                    if (BVALID && (BRESP != 2'b00)) error_r <= 1'b1;
                end
                S_RDATA: begin
                    if (r_hs_s) begin
                        rbeat_r <= rbeat_r + 9'd1;
                        if (r_bad_s) error_r <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Bench for axi4_burst_master: a responsive memory slave with fault injection,
// scenario tasks and randomized slave timing checked against an expected-result model.
module tb_axi4_burst_master;

    localparam int L = 8;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        start = 1'b0;
    logic        done, error;
    logic [3:0]  AWID, AWCACHE, AWQOS, AWREGION, ARID, ARCACHE, ARQOS, ARREGION;
    logic [31:0] AWADDR, ARADDR, WDATA;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT;
    logic [1:0]  AWBURST, ARBURST;
    logic        AWLOCK, AWUSER, ARLOCK, ARUSER, WUSER;
    logic        AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY;
    logic [3:0]  WSTRB;
    logic        AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0;
    logic        RVALID = 1'b0, RLAST = 1'b0;
    logic [1:0]  BRESP = 2'b00, RRESP = 2'b00;
    logic [31:0] RDATA = 32'd0;

    axi4_burst_master #(.C_ADDR_WIDTH(32), .C_BURST_LEN(L), .C_BASE_ADDR(32'd0)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .done(done), .error(error),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWQOS(AWQOS),
        .AWREGION(AWREGION), .AWUSER(AWUSER), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WUSER(WUSER), .WVALID(WVALID),
        .WREADY(WREADY), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARQOS(ARQOS),
        .ARREGION(ARREGION), .ARUSER(ARUSER), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int failures = 0;

    // slave configuration
    int          w_mode, aw_delay, bad_beat, rlast_beat;
    bit          r_rand, ar_rand;
    logic [1:0]  bresp_cfg;
    logic [31:0] bad_val;

    // monitor results
    logic [31:0] wq[$];
    bit          lq[$];
    int          aw_cnt, done_cnt, stall_viol, r_cnt, wv_cycles;
    logic [31:0] aw_addr_seen, ar_addr_seen;

    // slave internal state
    logic [31:0] mem [256];
    int          wcnt, aw_wait, rj;
    bit          aw_seen, wl_seen, b_hs, ar_seen, r_active, r_hs, w_stalled, wlast_hold;
    logic [31:0] w_hold;

    // Memory slave: decides ready/valid at the falling edge for the next rising edge.
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00; ARREADY = 1'b0;
            RVALID = 1'b0; RDATA = 32'd0; RRESP = 2'b00; RLAST = 1'b0;
            aw_seen = 1'b0; wl_seen = 1'b0; b_hs = 1'b0; ar_seen = 1'b0; r_active = 1'b0;
            r_hs = 1'b0; rj = 0; wcnt = 0; aw_wait = 0; w_stalled = 1'b0;
        end else begin
            if (w_stalled && (!WVALID || WDATA !== w_hold || WLAST !== wlast_hold)) stall_viol++;
            if (done) done_cnt++;
            if (WVALID) wv_cycles++;
            if (b_hs) begin
                BVALID = 1'b0; b_hs = 1'b0;
            end else if (aw_seen && wl_seen && !BVALID) begin
                BVALID = 1'b1; BRESP = bresp_cfg;
            end
            if (BVALID && BREADY) begin b_hs = 1'b1; aw_seen = 1'b0; wl_seen = 1'b0; end
            if (r_hs) begin
                r_hs = 1'b0; RVALID = 1'b0; r_cnt++; rj++;
                if (rj == L) r_active = 1'b0;
            end
            if (ar_seen) begin ar_seen = 1'b0; r_active = 1'b1; rj = 0; end
            if (r_active && !RVALID) RVALID = r_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (RVALID) begin
                RDATA = (rj == bad_beat) ? bad_val : mem[rj];
                RRESP = 2'b00;
                RLAST = (rj == L - 1) || (rj == rlast_beat);
            end else begin
                RLAST = 1'b0;
            end
            if (RVALID && RREADY) r_hs = 1'b1;
            ARREADY = ar_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (ARVALID && ARREADY) begin ar_seen = 1'b1; ar_addr_seen = ARADDR; end
            case (w_mode)
                0:       WREADY = 1'b1;
                1:       WREADY = !WREADY;
                default: WREADY = ($urandom_range(0, 1) == 1);
            endcase
            if (AWVALID) begin
                AWREADY = (aw_wait >= aw_delay); aw_wait++;
            end else begin
                AWREADY = 1'b0; aw_wait = 0;
            end
            if (AWVALID && AWREADY) begin aw_seen = 1'b1; aw_cnt++; aw_addr_seen = AWADDR; end
            if (WVALID && WREADY) begin
                wq.push_back(WDATA); lq.push_back(WLAST);
                mem[wcnt] = WDATA; wcnt++;
                if (WLAST) begin wl_seen = 1'b1; wcnt = 0; end
            end
            w_stalled = WVALID && !WREADY; w_hold = WDATA; wlast_hold = WLAST;
        end
    end

    task automatic set_defaults();
        w_mode = 0; aw_delay = 0; bad_beat = -1; rlast_beat = -1;
        r_rand = 1'b0; ar_rand = 1'b0; bresp_cfg = 2'b00; bad_val = 32'd0;
    endtask

    task automatic clear_mon();
        @(posedge ACLK); #1;
        wq.delete(); lq.delete();
        aw_cnt = 0; done_cnt = 0; stall_viol = 0; r_cnt = 0; wv_cycles = 0; wcnt = 0;
        aw_addr_seen = 32'hFFFF_FFFF; ar_addr_seen = 32'hFFFF_FFFF;
    endtask

    // Launch one test with a one-cycle start; returns cycles to done and error after launch.
    task automatic run_test(output int lat, output bit ok, output logic err0);
        @(negedge ACLK); #1; start = 1'b1;
        ok = 1'b0; lat = -1; err0 = 1'bx;
        for (int e = 0; e < 3000; e++) begin
            @(negedge ACLK); #1; start = 1'b0;
            if (e == 0) err0 = error;
            if (done) begin ok = 1'b1; lat = e; break; end
        end
    endtask

    // Count write beats deviating from the expected 1..L incrementing burst.
    function automatic int wbeat_errors();
        int n = 0;
        if (wq.size() != L) n++;
        for (int i = 0; i < wq.size(); i++) begin
            if (wq[i] !== 32'(i + 1) || lq[i] !== (i == L - 1)) n++;
        end
        return n;
    endfunction

    task automatic test_reset();
        logic [7:0] ctl;
        #1;
        ctl = {done, error, AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY};
        checks++;
        if (ctl !== 8'd0) begin failures++; $display("FAIL reset_ctl got=%b exp=00000000", ctl); end
        checks++;
        if ({AWADDR, ARADDR} !== 64'd0) begin
            failures++; $display("FAIL reset_addr got=%h/%h exp=0/0", AWADDR, ARADDR);
        end
        checks++;
        if ({AWLEN, ARLEN, AWSIZE, ARSIZE, AWBURST, ARBURST, WSTRB} !==
            {8'd7, 8'd7, 3'b010, 3'b010, 2'b01, 2'b01, 4'hF}) begin
            failures++;
            $display("FAIL const_fields got len=%0d/%0d size=%0d/%0d burst=%0d/%0d strb=%h",
                     AWLEN, ARLEN, AWSIZE, ARSIZE, AWBURST, ARBURST, WSTRB);
        end
        checks++;
        if ({AWID, AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, AWUSER, WUSER,
             ARID, ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARUSER} !== 41'd0) begin
            failures++; $display("FAIL sideband_zero got nonzero exp=0");
        end
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (5) @(negedge ACLK);
        checks++;
        if ({AWVALID, WVALID, ARVALID, done} !== 4'd0) begin
            failures++; $display("FAIL idle_no_start got=%b exp=0000", {AWVALID, WVALID, ARVALID, done});
        end
    endtask

    task automatic test_basic();
        int lat; bit ok; logic e0; int nbad;
        set_defaults(); clear_mon();
        run_test(lat, ok, e0);
        checks++;
        if (!ok || lat != 2 * L + 4) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, 2 * L + 4); end
        nbad = wbeat_errors();
        checks++;
        if (nbad != 0) begin failures++; $display("FAIL basic_wdata bad_beats=%0d of %0d exp=0", nbad, wq.size()); end
        checks++;
        if (aw_cnt != 1 || aw_addr_seen !== 32'd0 || ar_addr_seen !== 32'd0) begin
            failures++; $display("FAIL basic_addr got aw_cnt=%0d aw=%h ar=%h exp=1/0/0", aw_cnt, aw_addr_seen, ar_addr_seen);
        end
        checks++;
        if (r_cnt != L || error !== 1'b0) begin
            failures++; $display("FAIL basic_read got beats=%0d error=%b exp=%0d/0", r_cnt, error, L);
        end
        repeat (4) @(negedge ACLK); #1;
        checks++;
        if (done_cnt != 1 || done !== 1'b0) begin
            failures++; $display("FAIL basic_done_pulse got count=%0d done=%b exp=1/0", done_cnt, done);
        end
    endtask

    task automatic test_stall();
        int lat; bit ok; logic e0; int nbad;
        set_defaults(); w_mode = 1; aw_delay = 5; clear_mon();
        run_test(lat, ok, e0);
        nbad = wbeat_errors();
        checks++;
        if (!ok || nbad != 0 || aw_cnt != 1) begin
            failures++; $display("FAIL stall_beats got ok=%b bad=%0d beats=%0d aw=%0d exp=1/0/%0d/1", ok, nbad, wq.size(), aw_cnt, L);
        end
        checks++;
        if (stall_viol != 0 || error !== 1'b0) begin
            failures++; $display("FAIL stall_hold got viol=%0d error=%b exp=0/0", stall_viol, error);
        end
    endtask

    task automatic test_bad_rdata();
        int lat; bit ok; logic e0;
        set_defaults(); bad_beat = 2; bad_val = 32'h0000_0004; clear_mon();
        run_test(lat, ok, e0);
        checks++;
        if (!ok || error !== 1'b1) begin failures++; $display("FAIL bad_rdata_err got ok=%b error=%b exp=1/1", ok, error); end
        repeat (10) @(negedge ACLK); #1;
        checks++;
        if (error !== 1'b1) begin failures++; $display("FAIL error_sticky got=%b exp=1", error); end
        set_defaults(); clear_mon();
        run_test(lat, ok, e0);
        checks++;
        if (e0 !== 1'b0) begin failures++; $display("FAIL error_clear_on_start got=%b exp=0", e0); end
        checks++;
        if (!ok || error !== 1'b0) begin failures++; $display("FAIL clean_rerun got ok=%b error=%b exp=1/0", ok, error); end
    endtask

    task automatic test_bresp_rlast();
        int lat; bit ok; logic e0;
        set_defaults(); bresp_cfg = 2'b10; clear_mon();
        run_test(lat, ok, e0);
        checks++;
        if (!ok || r_cnt != L || error !== 1'b1) begin
            failures++; $display("FAIL bresp_slverr got ok=%b beats=%0d error=%b exp=1/%0d/1", ok, r_cnt, error, L);
        end
        set_defaults(); rlast_beat = 6; clear_mon();
        run_test(lat, ok, e0);
        checks++;
        if (!ok || r_cnt != L || error !== 1'b1) begin
            failures++; $display("FAIL early_rlast got ok=%b beats=%0d error=%b exp=1/%0d/1", ok, r_cnt, error, L);
        end
    endtask

    task automatic test_random();
        int lat; bit ok; logic e0; int nbad; int fault; bit exp_err;
        for (int it = 0; it < 12; it++) begin
            set_defaults();
            w_mode = 2; r_rand = 1'b1; ar_rand = 1'b1;
            aw_delay = $urandom_range(0, 6);
            fault = $urandom_range(0, 3);
            case (fault)
                1: bresp_cfg = 2'($urandom_range(1, 3));
                2: begin bad_beat = $urandom_range(0, L - 1); bad_val = 32'(bad_beat + 1) + 32'd256; end
                3: rlast_beat = $urandom_range(0, L - 2);
                default: begin end
            endcase
            exp_err = (fault != 0);
            clear_mon();
            run_test(lat, ok, e0);
            nbad = wbeat_errors();
            checks++;
            if (!ok || nbad != 0 || stall_viol != 0 || r_cnt != L) begin
                failures++;
                $display("FAIL rand_xfer it=%0d got ok=%b bad=%0d viol=%0d rbeats=%0d exp=1/0/0/%0d", it, ok, nbad, stall_viol, r_cnt, L);
            end
            checks++;
            if (error !== exp_err) begin
                failures++; $display("FAIL rand_error it=%0d fault=%0d got=%b exp=%b", it, fault, error, exp_err);
            end
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2, n;
        set_defaults(); clear_mon();
        d1 = -1; d2 = -1; n = 0;
        @(negedge ACLK); #1; start = 1'b1;
        for (int e = 0; e < 200; e++) begin
            @(negedge ACLK); #1;
            if (done) begin
                if (n == 0) d1 = e; else d2 = e;
                n++;
                if (n == 2) begin start = 1'b0; break; end
            end
        end
        start = 1'b0;
        checks++;
        if (n != 2 || d2 - d1 != 2 * L + 5) begin
            failures++; $display("FAIL b2b_gap got dones=%0d gap=%0d exp=2/%0d", n, d2 - d1, 2 * L + 5);
        end
        repeat (30) @(negedge ACLK); #1;
        checks++;
        if (aw_cnt != 2 || done_cnt != 2 || error !== 1'b0) begin
            failures++; $display("FAIL b2b_count got aw=%0d done=%0d error=%b exp=2/2/0", aw_cnt, done_cnt, error);
        end
    endtask

    task automatic test_reset_mid();
        int lat; bit ok; logic e0; int nbad; logic pre_wv; logic [7:0] ctl;
        set_defaults(); clear_mon();
        @(negedge ACLK); #1; start = 1'b1;
        @(negedge ACLK); #1; start = 1'b0;
        for (int e = 0; e < 50; e++) begin
            if (wq.size() >= 4) break;
            @(negedge ACLK); #1;
        end
        pre_wv = WVALID;
        ARESETN = 1'b0;
        #1;
        ctl = {done, error, AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY};
        checks++;
        if (pre_wv !== 1'b1 || ctl !== 8'd0) begin
            failures++; $display("FAIL async_reset got pre_wvalid=%b ctl=%b exp=1/00000000", pre_wv, ctl);
        end
        repeat (2) @(negedge ACLK);
        #1; ARESETN = 1'b1;
        clear_mon();
        repeat (30) @(negedge ACLK); #1;
        checks++;
        if (done_cnt != 0 || wv_cycles != 0 || aw_cnt != 0) begin
            failures++; $display("FAIL reset_abandon got done=%0d wvalid_cycles=%0d aw=%0d exp=0/0/0", done_cnt, wv_cycles, aw_cnt);
        end
        clear_mon();
        run_test(lat, ok, e0);
        nbad = wbeat_errors();
        checks++;
        if (!ok || lat != 2 * L + 4 || nbad != 0 || error !== 1'b0) begin
            failures++; $display("FAIL post_reset_test got ok=%b lat=%0d bad=%0d error=%b exp=1/%0d/0/0", ok, lat, nbad, error, 2 * L + 4);
        end
    endtask

    initial begin
        set_defaults();
        test_reset();
        test_basic();
        test_stall();
        test_bad_rdata();
        test_bresp_rlast();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
